nes_controller_reader: RTL and testbench
========================================

NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

Interface
REQ-001 SHALL have parameter LATCH_CYCLES, default 300, meaning nes_latch high time in clk cycles (12 us at 25 MHz).
REQ-002 SHALL have parameter HALF_CYCLES, default 150, meaning each nes_clk low or high phase in clk cycles (6 us at 25 MHz).
REQ-003 SHALL have port clk  input  1  system clock, one clock domain; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  read request, sampled each clk (driven by frame_end).
REQ-006 SHALL have port nes_data  input  1  serial data from controller, active-low (0 = pressed), asynchronous to clk.
REQ-007 SHALL have port nes_latch  output  1  controller latch strobe, registered.
REQ-008 SHALL have port nes_clk  output  1  controller shift clock, registered, idle low.
REQ-009 SHALL have port buttons  output  8  last completed read, 1 = pressed; [0] A, [1] B, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right.
REQ-010 SHALL have port valid  output  1  one-cycle pulse when buttons updates.
REQ-011 SHALL have port busy  output  1  high while a read is in progress (any state other than IDLE).

Function
REQ-012 SHALL pass nes_data through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-013 SHALL implement the FSM states IDLE, LATCH, READ_LOW, READ_HIGH and DONE with one phase counter and a 3-bit bit index.
REQ-014 IDLE: nes_latch=0, nes_clk=0; start=1 at edge N SHALL move to LATCH at N and clear the bit index to 0.
REQ-015 LATCH: nes_latch=1 for exactly LATCH_CYCLES cycles, then SHALL move to READ_LOW.
REQ-016 READ_LOW: nes_clk=0 for HALF_CYCLES cycles; on its last cycle the block SHALL store ~sync_data into shift bit [index].
REQ-017 After READ_LOW: index=7 SHALL go to DONE; otherwise SHALL go to READ_HIGH.
REQ-018 READ_HIGH: nes_clk=1 for HALF_CYCLES cycles, then the index SHALL increment and the FSM SHALL return to READ_LOW.
REQ-019 A read SHALL produce exactly 1 latch pulse and 7 nes_clk pulses.
REQ-020 DONE (one cycle) SHALL copy the shift register to buttons, pulse valid=1 and return to IDLE.
REQ-021 Latency: valid SHALL be high in the cycle starting LATCH_CYCLES + 15*HALF_CYCLES + 1 cycles after the start-accept edge.
REQ-022 start SHALL be ignored while busy=1, including in the DONE cycle; there is no queueing.
REQ-023 buttons SHALL hold its value between reads and change only in DONE; partial reads SHALL never be visible.
REQ-024 The phase counter SHALL be wide enough for max(LATCH_CYCLES, HALF_CYCLES) and SHALL reload on every state entry.
REQ-025 A stuck-high nes_data (no controller connected) SHALL yield buttons=8'h00.

Reset
REQ-026 While reset=1, independent of clk, the block SHALL force: state=IDLE, nes_latch=0, nes_clk=0, buttons=8'h00, valid=0, busy=0, shift register, index, counter and synchronizer = 0.
REQ-027 Reset asserted mid-read SHALL abort the read with no valid pulse; buttons SHALL NOT keep the pre-reset value.
REQ-028 After reset deasserts, the block SHALL accept start on the first rising edge.

Verification (LATCH_CYCLES=4, HALF_CYCLES=2)
REQ-029 Controller model presents A..Right = pressed, released, released, pressed, pressed, released, released, pressed -> buttons=8'b1001_1001 and valid pulse 35 cycles after the start edge.
REQ-030 nes_data held 1 -> buttons=8'h00, valid pulse, exactly 4-cycle latch and 7 nes_clk pulses each 2 cycles high.
REQ-031 start pulsed again 10 cycles into a read, and start held high continuously -> second request ignored; continuous start gives back-to-back reads separated by one IDLE cycle.
REQ-032 reset asserted during READ_HIGH of bit 3 -> nes_clk and nes_latch drop asynchronously, no valid, buttons=8'h00; next start completes normally.
REQ-033 Only Right pressed, then next read only A pressed -> buttons 8'h80 then 8'h01; value stable between valid pulses.

Source files
------------

// File: rtl/nes_controller_reader_if.sv
// nes_controller_reader_if
//   Groups the request and status signals of the NES controller reader, and the
//   controller-side pins.
//   master : the reader. It drives nes_latch, nes_clk, buttons, valid and busy,
//            and it samples start and nes_data.
//   slave  : the environment. It drives start and nes_data, and it observes
//            the reader outputs.
interface nes_controller_reader_if;
  logic       start;      // read request (frame_end)
  logic       nes_data;   // serial data from the controller, active-low
  logic       nes_latch;  // controller latch strobe
  logic       nes_clk;    // controller shift clock, idle low
  logic [7:0] buttons;    // last completed read, 1 = pressed
  logic       valid;      // one-cycle pulse when buttons updates
  logic       busy;       // read in progress

  modport master (
    input  start, nes_data,
    output nes_latch, nes_clk, buttons, valid, busy
  );

  modport slave (
    output start, nes_data,
    input  nes_latch, nes_clk, buttons, valid, busy
  );
endinterface

// File: rtl/nes_controller_reader.sv
// nes_controller_reader
//   Reads an NES controller. A start request latches the pad and then clocks
//   out 8 serial bits. The bit order is A, B, Select, Start, Up, Down, Left,
//   Right. The result is published on buttons with a one-cycle valid pulse.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high
//     bus   : nes_controller_reader_if.master
//             inputs  : start, nes_data
//             outputs : nes_latch, nes_clk, buttons, valid, busy
//   Parameters:
//     LATCH_CYCLES : nes_latch high time, in clk cycles
//     HALF_CYCLES  : length of each nes_clk low phase and each high phase
module nes_controller_reader #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150
) (
  input logic                     clk,
  input logic                     reset,
  nes_controller_reader_if.master bus
);

  typedef enum logic [2:0] {IDLE, LATCH, READ_LOW, READ_HIGH, DONE} state_t;

  localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LATCH_LD = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LD  = CW'(HALF_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;     // counts down to 0 within the current phase
  logic [2:0]    idx_q;     // index of the bit being read
  logic [7:0]    shift_q;   // partial result; it is never visible on buttons
  logic [7:0]    buttons_q;
  logic [1:0]    sync_q;    // nes_data synchronizer, [1] is the safe value
  logic          latch_q, nclk_q, valid_q, busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], bus.nes_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      buttons_q <= 8'h00;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= LATCH;
            cnt_q   <= LATCH_LD;
            idx_q   <= 3'd0;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LATCH: begin
          if (cnt_q == '0) begin
            state_q <= READ_LOW;
            cnt_q   <= HALF_LD;
            latch_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        READ_LOW: begin
          if (cnt_q == '0) begin
            // Sample at the end of the low phase. Data has then been stable
            // since the previous nes_clk rise, including the synchronizer delay.
            shift_q[idx_q] <= ~sync_q[1];
            if (idx_q == 3'd7) begin
              state_q <= DONE;
              cnt_q   <= '0;
            end else begin
              state_q <= READ_HIGH;
              cnt_q   <= HALF_LD;
              nclk_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        READ_HIGH: begin
          if (cnt_q == '0) begin
            state_q <= READ_LOW;
            cnt_q   <= HALF_LD;
            nclk_q  <= 1'b0;
            idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // start is ignored here. The earliest possible restart comes after
          // one IDLE cycle.
          buttons_q <= shift_q;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
          cnt_q     <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          latch_q <= 1'b0;
          nclk_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.nes_latch = latch_q;
  assign bus.nes_clk   = nclk_q;
  assign bus.buttons   = buttons_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// tb_nes_controller_reader
//   Bench for nes_controller_reader with LATCH_CYCLES=4 and HALF_CYCLES=2.
//   A controller model drives nes_data from the bench pattern: bit k appears
//   after k nes_clk rises that follow the latch.
//   The scoreboard compares each valid pulse against the queued expected
//   buttons and the expected start-to-valid latency.
module tb_nes_controller_reader;
  localparam int L   = 4;
  localparam int H   = 2;
  localparam int LAT = L + 15 * H + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  nes_controller_reader_if bus();

  nes_controller_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] btn;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0, cyc = 0, nvalid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model
  int         k     = 8;
  logic [7:0] pat   = 8'h00;
  bit         stuck = 1'b0;
  always @(posedge bus.nes_latch or posedge bus.nes_clk) begin
    if (bus.nes_latch) k = 0;
    else               k = k + 1;
  end
  assign bus.nes_data = (stuck || k > 7) ? 1'b1 : ~pat[k[2:0]];

  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.valid === 1'b1) begin
        nvalid++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid buttons=%h at cyc %0d", bus.buttons, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.buttons !== e.btn) begin
            bad++;
            $display("FAIL sb_buttons got=%h want=%h", bus.buttons, e.btn);
          end
          total++;
          if (cyc - e.acc != LAT) begin
            bad++;
            $display("FAIL sb_latency got=%0d want=%0d", cyc - e.acc, LAT);
          end
        end
      end
    end
  endtask

  // Call at a negedge. Drives start for one cycle and queues the expected result.
  task automatic start_read(input logic [7:0] p, input logic [7:0] expv);
    pat = p;
    bus.start = 1'b1;
    exp_q.push_back('{btn: expv, acc: cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit to);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    to = (exp_q.size() != 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.nes_latch !== 1'b0 || bus.nes_clk !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes latch=%b clk=%b want 0 0", bus.nes_latch, bus.nes_clk);
    end
    total++;
    if (bus.buttons !== 8'h00) begin
      bad++;
      $display("FAIL reset_buttons got=%h want=00", bus.buttons);
    end
    total++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags valid=%b busy=%b want 0 0", bus.valid, bus.busy);
    end
    bus.start = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_start busy=%b want 0", bus.busy);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_pattern();
    bit to;
    start_read(8'b1001_1001, 8'b1001_1001);
    wait_drain(60, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL pattern_timeout got=no_valid want=valid");
    end
    @(negedge clk);
    total++;
    if (bus.buttons !== 8'b1001_1001) begin
      bad++;
      $display("FAIL pattern_hold got=%h want=99", bus.buttons);
    end
  endtask

  task automatic test_stuck();
    int latch_cnt = 0, rises = 0, run = 0, badruns = 0, n = 0;
    logic pclk = 1'b0;
    stuck = 1'b1;
    start_read(8'hFF, 8'h00);
    // The first latch cycle was seen at the negedge inside start_read.
    if (bus.nes_latch === 1'b1) latch_cnt++;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.nes_latch === 1'b1) latch_cnt++;
      if (bus.nes_clk === 1'b1) begin
        if (!pclk) rises++;
        run++;
      end else begin
        if (pclk && run != H) badruns++;
        run = 0;
      end
      pclk = bus.nes_clk;
    end
    stuck = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL stuck_timeout got=no_valid want=valid");
    end
    total++;
    if (latch_cnt != L) begin
      bad++;
      $display("FAIL latch_width got=%0d want=%0d", latch_cnt, L);
    end
    total++;
    if (rises != 7) begin
      bad++;
      $display("FAIL nes_clk_pulses got=%0d want=7", rises);
    end
    total++;
    if (badruns != 0) begin
      bad++;
      $display("FAIL nes_clk_high_width bad_runs=%0d want=0", badruns);
    end
  endtask

  task automatic test_restart_ignored();
    bit to;
    int nv0 = nvalid;
    start_read(8'h5A, 8'h5A);
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(60, to);
    repeat (45) @(negedge clk);
    total++;
    if (to || nvalid - nv0 != 1) begin
      bad++;
      $display("FAIL restart_ignored valids=%0d want=1", nvalid - nv0);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_idle busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int a1, a2;
    int nv0 = nvalid;
    pat = 8'hC3;
    bus.start = 1'b1;
    a1 = cyc + 1;
    a2 = a1 + LAT + 1;
    exp_q.push_back('{btn: 8'hC3, acc: a1});
    exp_q.push_back('{btn: 8'hC3, acc: a2});
    while (cyc < a2) begin
      @(negedge clk);
      if (cyc == a1 + LAT) begin
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL b2b_gap busy=%b want 0", bus.busy);
        end
      end
    end
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_busy busy=%b want 1", bus.busy);
    end
    wait_drain(60, to);
    repeat (5) @(negedge clk);
    total++;
    if (to || nvalid - nv0 != 2) begin
      bad++;
      $display("FAIL b2b_count valids=%0d want=2", nvalid - nv0);
    end
  endtask

  task automatic test_reset_abort();
    bit to;
    int acc, nv0;
    acc = cyc + 1;
    start_read(8'hFF, 8'hFF);
    while (cyc < acc + 18) @(negedge clk);
    total++;
    if (bus.nes_clk !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_high nes_clk=%b want 1", bus.nes_clk);
    end
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    nv0 = nvalid;
    total++;
    if (bus.nes_clk !== 1'b0 || bus.nes_latch !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_async clk=%b latch=%b busy=%b want 0 0 0",
               bus.nes_clk, bus.nes_latch, bus.busy);
    end
    total++;
    if (bus.buttons !== 8'h00 || bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs buttons=%h valid=%b want 00 0", bus.buttons, bus.valid);
    end
    repeat (4) @(negedge clk);
    reset = 1'b0;
    start_read(8'h24, 8'h24);
    wait_drain(60, to);
    total++;
    if (to || nvalid - nv0 != 1) begin
      bad++;
      $display("FAIL abort_recover valids=%0d want=1", nvalid - nv0);
    end
  endtask

  task automatic test_two_reads();
    bit to;
    int n = 0, unstable = 0;
    start_read(8'h80, 8'h80);
    wait_drain(60, to);
    repeat (5) @(negedge clk);
    total++;
    if (to || bus.buttons !== 8'h80) begin
      bad++;
      $display("FAIL right_only got=%h want=80", bus.buttons);
    end
    start_read(8'h01, 8'h01);
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.valid !== 1'b1 && exp_q.size() != 0 && bus.buttons !== 8'h80) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL buttons_stable changes=%0d want=0", unstable);
    end
    @(negedge clk);
    total++;
    if (bus.buttons !== 8'h01) begin
      bad++;
      $display("FAIL a_only got=%h want=01", bus.buttons);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_pattern();
    test_stuck();
    test_restart_ignored();
    test_back_to_back();
    test_reset_abort();
    test_two_reads();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
